// File: rtl/puf_key_reconstruct.sv
// PUF key reconstruction: fetch helper parity, sample the PUF, BCH-correct the
// response (retrying on uncorrectable results) and hand the key to the consumer.

// Double-error-correcting BCH(44,32) decoder, shortened from BCH(63,51).
// g(x) = x^12+x^10+x^8+x^5+x^4+x^3+1; data bit k sits at x^(k+12), parity bit j at x^j.
module bch_dec_dcd_univ_top (
  input  logic [31:0] data,
  input  logic [11:0] parity,
  output logic [31:0] mask,
  output logic        error
);
  localparam int CW_W = 44;
  localparam logic [11:0] G_LOW = 12'h539;

  function automatic logic [11:0] pos_rem(input int pos);
    logic [11:0] r;
    r = 12'h001;
    for (int s = 0; s < pos; s++)
      r = r[11] ? ({r[10:0], 1'b0} ^ G_LOW) : {r[10:0], 1'b0};
    return r;
  endfunction

  logic [CW_W-1:0] cw;
  logic [11:0]     rem_tab [CW_W];
  logic [11:0]     syn;
  logic [CW_W-1:0] hit;
  logic            found;

  assign cw = {data, parity};

  for (genvar gi = 0; gi < CW_W; gi++) begin : g_rem
    assign rem_tab[gi] = pos_rem(gi);
  end

  // Minimum distance 5 makes every weight<=2 syndrome unique, so OR-ing hits is safe.
  always_comb begin
    syn   = '0;
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < CW_W; i++)
      if (cw[i]) syn = syn ^ rem_tab[i];
    for (int i = 0; i < CW_W; i++) begin
      if (syn == rem_tab[i]) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < CW_W - 1; i++) begin
      for (int j = i + 1; j < CW_W; j++) begin
        if (syn == (rem_tab[i] ^ rem_tab[j])) begin
          hit[i] = 1'b1;
          hit[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    mask  = hit[CW_W-1:12];
    error = (syn != 12'd0) && !found;
  end
endmodule

module puf_key_reconstruct #(
  parameter int DATA_W    = 32,
  parameter int PAR_W     = 12,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              hd_rd_en,
  input  logic              hd_rd_valid,
  input  logic [PAR_W-1:0]  hd_rd_data,
  output logic              puf_req,
  input  logic              puf_valid,
  input  logic [DATA_W-1:0] puf_resp,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [DATA_W-1:0] key,
  output logic [5:0]        err_count,
  output logic [1:0]        status,
  output logic [2:0]        dbg_state
);
  // Handshakes: a transfer on key happens in a cycle where key_valid && key_ready;
  // key_valid holds with stable key/err_count/status until that cycle.
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SAMPLE, S_DECODE, S_CHECK, S_DONE
  } state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_UNC = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [2:0] RETRY_LAST = 3'(MAX_RETRY);

  state_t            state, state_n;
  logic [PAR_W-1:0]  par_reg;
  logic [DATA_W-1:0] resp_reg;
  logic              err_flag;
  logic [2:0]        retry_cnt;
  logic [7:0]        tmo_cnt;
  logic              tmo_hit;
  logic [DATA_W-1:0] dec_mask;
  logic              dec_err;
  logic [5:0]        mask_pop;

  bch_dec_dcd_univ_top u_dec (
    .data   (resp_reg),
    .parity (par_reg),
    .mask   (dec_mask),
    .error  (dec_err)
  );

  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < DATA_W; i++)
      mask_pop = mask_pop + {5'd0, dec_mask[i]};
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b1;
    puf_req   = 1'b0;
    key_valid = 1'b0;
    tmo_hit   = (tmo_cnt == TMO_LAST);
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (hd_rd_valid)  state_n = S_SAMPLE;
        else if (tmo_hit) state_n = S_DONE;
      end
      S_SAMPLE: begin
        puf_req = 1'b1;
        if (puf_valid)    state_n = S_DECODE;
        else if (tmo_hit) state_n = S_DONE;
      end
      S_DECODE: state_n = S_CHECK;
      S_CHECK: begin
        if (!err_flag || retry_cnt == RETRY_LAST) state_n = S_DONE;
        else                                      state_n = S_SAMPLE;
      end
      S_DONE: begin
        key_valid = 1'b1;
        if (key_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_rd_en  <= 1'b0;
      par_reg   <= '0;
      resp_reg  <= '0;
      err_flag  <= 1'b0;
      retry_cnt <= '0;
      tmo_cnt   <= '0;
      key       <= '0;
      err_count <= '0;
      status    <= ST_OK;
    end else begin
      hd_rd_en <= (state == S_IDLE) && start;
      case (state)
        S_IDLE: begin
          if (start) begin
            tmo_cnt   <= '0;
            retry_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (hd_rd_valid) begin
            par_reg <= hd_rd_data;
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            key       <= '0;
            err_count <= '0;
            status    <= ST_TMO;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_SAMPLE: begin
          if (puf_valid) begin
            resp_reg <= puf_resp;
          end else if (tmo_hit) begin
            key       <= '0;
            err_count <= '0;
            status    <= ST_TMO;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          key       <= resp_reg ^ dec_mask;
          err_count <= mask_pop;
          err_flag  <= dec_err;
        end
        S_CHECK: begin
          if (!err_flag) begin
            status <= ST_OK;
          end else if (retry_cnt == RETRY_LAST) begin
            status <= ST_UNC;
          end else begin
            retry_cnt <= retry_cnt + 3'd1;
            tmo_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
